// File: rtl/reset_watchdog.sv
// Reset sequencer + watchdog: releases nRESETP after a power-on hold, nRESET a few cycles later, and re-pulses both on a watchdog timeout.
// Latency: nRESETP rises POR_CYCLES edges after RESET drops; nRESET lags by NRESET_LAG; a fire comes PRESCALE*WDOG_LIMIT edges after the last kick.
// Backpressure: none; WDOG_KICK is a fire-and-forget strobe, and all outputs are registered.
//
// Ports:
//   CLK_24M     in   master clock, all logic on posedge
//   RESET       in   synchronous active-high reset
//   WDOG_EN     in   watchdog enable (0 forces prescaler and tick counter to zero)
//   WDOG_KICK   in   single-cycle kick strobe, synchronous to CLK_24M
//   nRESETP     out  active-low reset to the clock divider
//   nRESET      out  active-low 68K/system reset, lags nRESETP on release
//   WDOG_FIRED  out  sticky flag, set by any watchdog fire, cleared only by RESET
//   WDOG_CNT    out  current watchdog tick count (debug)

module reset_watchdog #(
   parameter int POR_CYCLES   = 64,
   parameter int NRESET_LAG   = 8,
   parameter int PRESCALE     = 16,
   parameter int WDOG_LIMIT   = 1024,
   parameter int PULSE_CYCLES = 32
) (
   input  logic                        CLK_24M,
   input  logic                        RESET,
   input  logic                        WDOG_EN,
   input  logic                        WDOG_KICK,
   output logic                        nRESETP,
   output logic                        nRESET,
   output logic                        WDOG_FIRED,
   output logic [$clog2(WDOG_LIMIT):0] WDOG_CNT
);

   // Every parameter is a count of cycles or ticks; zero would make the
   // terminal compares below unreachable.
   if (POR_CYCLES < 1 || NRESET_LAG < 1 || PRESCALE < 1 ||
       WDOG_LIMIT < 1 || PULSE_CYCLES < 1) begin : g_param_err
      $error("reset_watchdog: every parameter must be >= 1");
   end

   // HOLD, LAG and FIRE never overlap, so one sequencing counter serves all
   // three; it only has to reach the largest of their terminal values.
   localparam int SEQ_MAX = (POR_CYCLES > NRESET_LAG)
                          ? ((POR_CYCLES > PULSE_CYCLES) ? POR_CYCLES : PULSE_CYCLES)
                          : ((NRESET_LAG > PULSE_CYCLES) ? NRESET_LAG : PULSE_CYCLES);
   localparam int SW = $clog2(SEQ_MAX + 1);
   // PRESCALE=1 would give a zero-width prescaler; keep one bit that stays 0.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = $clog2(WDOG_LIMIT) + 1;

   localparam logic [SW-1:0] POR_LAST   = SW'(POR_CYCLES - 1);
   localparam logic [SW-1:0] LAG_LAST   = SW'(NRESET_LAG - 1);
   localparam logic [SW-1:0] PULSE_LAST = SW'(PULSE_CYCLES - 1);
   localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] TICK_LAST  = CW'(WDOG_LIMIT - 1);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_LAG  = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIRE = 2'd3
   } state_t;

   state_t        state_q;
   logic [SW-1:0] seq_q;
   logic [PW-1:0] presc_q;
   logic [CW-1:0] tick_q;
   logic          nresetp_q;
   logic          nreset_q;
   logic          fired_q;

   // Combinational next values for the watchdog counters in RUN.
   logic [SW-1:0] seq_d;
   logic [PW-1:0] presc_d;
   logic [CW-1:0] tick_d;
   logic          presc_wrap;
   logic          tick_term;

   always_comb begin
      seq_d      = seq_q + SW'(1);
      presc_wrap = (presc_q == PRE_LAST);
      tick_term  = presc_wrap && (tick_q == TICK_LAST);
      presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
      tick_d     = presc_wrap ? tick_q + CW'(1) : tick_q;
   end

   always_ff @(posedge CLK_24M) begin
      if (RESET) begin
         state_q   <= ST_HOLD;
         seq_q     <= '0;
         presc_q   <= '0;
         tick_q    <= '0;
         nresetp_q <= 1'b0;
         nreset_q  <= 1'b0;
         fired_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               presc_q <= '0;
               tick_q  <= '0;
               if (seq_q == POR_LAST) begin
                  state_q   <= ST_LAG;
                  seq_q     <= '0;
                  nresetp_q <= 1'b1;
               end else begin
                  seq_q <= seq_d;
               end
            end

            ST_LAG: begin
               presc_q <= '0;
               tick_q  <= '0;
               if (seq_q == LAG_LAST) begin
                  state_q  <= ST_RUN;
                  seq_q    <= '0;
                  nreset_q <= 1'b1;
               end else begin
                  seq_q <= seq_d;
               end
            end

            ST_RUN: begin
               // A kick or a disable outranks the terminal tick, so a kick
               // landing on the timeout edge still prevents the fire.
               if (!WDOG_EN || WDOG_KICK) begin
                  presc_q <= '0;
                  tick_q  <= '0;
               end else if (tick_term) begin
                  state_q   <= ST_FIRE;
                  seq_q     <= '0;
                  presc_q   <= '0;
                  tick_q    <= '0;
                  nresetp_q <= 1'b0;
                  nreset_q  <= 1'b0;
                  fired_q   <= 1'b1;
               end else begin
                  presc_q <= presc_d;
                  tick_q  <= tick_d;
               end
            end

            ST_FIRE: begin
               // The entry edge is pulse cycle 1, so the counter starting at
               // zero on entry hits PULSE_CYCLES-1 on the release edge.
               presc_q <= '0;
               tick_q  <= '0;
               if (seq_q == PULSE_LAST) begin
                  state_q   <= ST_LAG;
                  seq_q     <= '0;
                  nresetp_q <= 1'b1;
               end else begin
                  seq_q <= seq_d;
               end
            end

            default: begin
               state_q   <= ST_HOLD;
               seq_q     <= '0;
               presc_q   <= '0;
               tick_q    <= '0;
               nresetp_q <= 1'b0;
               nreset_q  <= 1'b0;
            end
         endcase
      end
   end

   assign nRESETP    = nresetp_q;
   assign nRESET     = nreset_q;
   assign WDOG_FIRED = fired_q;
   assign WDOG_CNT   = tick_q;

endmodule

// File: tb/tb_reset_watchdog.sv
// Directed bench for reset_watchdog with default parameters
// (POR 64, lag 8, prescale 16, limit 1024, pulse 32).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_reset_watchdog;

   logic        clk;
   logic        rst;
   logic        wdog_en;
   logic        wdog_kick;
   logic        nresetp;
   logic        nreset;
   logic        fired;
   logic [10:0] wcnt;

   int n_cmp = 0;
   int n_err = 0;

   reset_watchdog dut (
      .CLK_24M    (clk),
      .RESET      (rst),
      .WDOG_EN    (wdog_en),
      .WDOG_KICK  (wdog_kick),
      .nRESETP    (nresetp),
      .nRESET     (nreset),
      .WDOG_FIRED (fired),
      .WDOG_CNT   (wcnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Walk the 64/72 power-on release from the edge where RESET was dropped.
   task automatic power_on(input string tag);
      step(63);
      chk({tag, "_nrp_63"}, nresetp, 0);
      step(1);
      chk({tag, "_nrp_64"}, nresetp, 1);
      chk({tag, "_nr_64"},  nreset, 0);
      step(7);
      chk({tag, "_nr_71"},  nreset, 0);
      step(1);
      chk({tag, "_nr_72"},  nreset, 1);
      chk({tag, "_cnt_72"}, wcnt, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within time bound");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst       = 1'b1;
      wdog_en   = 1'b1;
      wdog_kick = 1'b0;

      // Reset held for 5 edges.
      step(5);
      chk("rst_nrp",   nresetp, 0);
      chk("rst_nr",    nreset, 0);
      chk("rst_fired", fired, 0);
      chk("rst_cnt",   wcnt, 0);

      // Power-on release.
      rst = 1'b0;
      power_on("por");
      chk("por_fired", fired, 0);

      // One tick after 16 enabled edges in RUN.
      step(16);
      chk("tick1_cnt", wcnt, 1);

      // Periodic kick after 16000 edges: count reads exactly 1000.
      step(16000 - 16);
      chk("kick_pre_cnt", wcnt, 1000);
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
      chk("kick_post_cnt", wcnt, 0);
      chk("kick_post_nrp", nresetp, 1);

      // Kick exactly on the terminal edge: no fire.
      step(16383);
      chk("term_pre_cnt", wcnt, 1023);
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
      chk("term_kick_cnt",   wcnt, 0);
      chk("term_kick_nrp",   nresetp, 1);
      chk("term_kick_fired", fired, 0);

      // No further kicks: fire 16384 edges after the terminal kick.
      step(16383);
      chk("to_pre_cnt", wcnt, 1023);
      chk("to_pre_nr",  nreset, 1);
      step(1);
      chk("to_fire_nrp",   nresetp, 0);
      chk("to_fire_nr",    nreset, 0);
      chk("to_fire_fired", fired, 1);
      chk("to_fire_cnt",   wcnt, 0);

      // Fire pulse is 32 edges; a kick inside it is ignored.
      step(5);
      wdog_kick = 1'b1;
      step(1);
      wdog_kick = 1'b0;
      step(25);
      chk("pulse_31_nrp", nresetp, 0);
      chk("pulse_31_cnt", wcnt, 0);
      step(1);
      chk("pulse_32_nrp", nresetp, 1);
      chk("pulse_32_nr",  nreset, 0);
      chk("pulse_32_cnt", wcnt, 0);
      step(7);
      chk("relag_39_nr", nreset, 0);
      step(1);
      chk("relag_40_nr",    nreset, 1);
      chk("relag_40_fired", fired, 1);

      // Watchdog disabled for 1000 edges: counters held, no fire.
      wdog_en = 1'b0;
      step(1000);
      chk("dis_cnt",   wcnt, 0);
      chk("dis_nrp",   nresetp, 1);
      chk("dis_nr",    nreset, 1);

      // Re-enable: full 16384-edge interval from zero.
      wdog_en = 1'b1;
      step(16383);
      chk("reen_pre_cnt", wcnt, 1023);
      chk("reen_pre_nrp", nresetp, 1);
      step(1);
      chk("reen_fire_nrp",   nresetp, 0);
      chk("reen_fire_fired", fired, 1);

      // RESET at pulse cycle 10 of the fire.
      step(9);
      rst = 1'b1;
      step(1);
      chk("midfire_nrp",   nresetp, 0);
      chk("midfire_nr",    nreset, 0);
      chk("midfire_fired", fired, 0);
      chk("midfire_cnt",   wcnt, 0);
      rst = 1'b0;

      // Restart, then RESET three edges into LAG.
      step(64);
      chk("lag_entry_nrp", nresetp, 1);
      step(3);
      chk("lag_3_nr", nreset, 0);
      rst = 1'b1;
      step(1);
      chk("midlag_nrp",   nresetp, 0);
      chk("midlag_nr",    nreset, 0);
      chk("midlag_fired", fired, 0);
      rst = 1'b0;
      power_on("por2");
      chk("por2_fired", fired, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
